// File: rtl/board_id_reader.sv
// board_id_reader: scans board type/revision straps from a 74HC165 chain and presents debounced values
module board_id_reader #(
  parameter int C_BOARD_TYPE_WIDTH = 4,
  parameter int C_BOARD_REV_WIDTH  = 4,
  parameter int C_SCLK_DIV         = 8,
  parameter int C_REFRESH_CYCLES   = 1000000
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  output logic                          id_load_n,
  output logic                          id_sclk,
  input  logic                          id_sdata,
  input  logic                          rescan,
  output logic [C_BOARD_TYPE_WIDTH-1:0] board_type,
  output logic [C_BOARD_REV_WIDTH-1:0]  board_rev,
  output logic                          id_valid,
  output logic                          id_mismatch,
  output logic                          busy
);
  localparam int N  = C_BOARD_TYPE_WIDTH + C_BOARD_REV_WIDTH;
  localparam int CW = $clog2(C_SCLK_DIV);
  localparam int BW = $clog2(N);
  localparam int DW = $clog2(C_REFRESH_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SHIFT, COMPARE} state_e;
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            ph_q, ph_d;
  logic [N-1:0]    shift_q, shift_d, prev_q, prev_d, out_q, out_d;
  logic            prev_ok_q, prev_ok_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [1:0]      sync_q;
  logic            load_n_q, load_n_d;
  logic            valid_q, valid_d, mism_q, mism_d;
  logic            cnt_end;
  assign cnt_end     = cnt_q == CW'(C_SCLK_DIV - 1);
  assign id_load_n   = load_n_q;
  assign id_sclk     = ph_q;
  assign busy        = state_q != IDLE;
  assign board_type  = out_q[N-1 -: C_BOARD_TYPE_WIDTH];
  assign board_rev   = out_q[C_BOARD_REV_WIDTH-1:0];
  assign id_valid    = valid_q;
  assign id_mismatch = mism_q;
  // Next-state logic: scan sequencing, bit capture and compare/debounce decision
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    ph_d      = ph_q;
    shift_d   = shift_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    dwell_d   = dwell_q;
    out_d     = out_q;
    valid_d   = valid_q;
    mism_d    = 1'b0;
    case (state_q)
      IDLE: begin
        dwell_d = dwell_q - DW'(1);
        if (rescan || dwell_q == DW'(1)) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = cnt_end ? '0 : cnt_q + CW'(1);
        state_d = cnt_end ? SETTLE : LOAD;
      end
      SETTLE: begin
        cnt_d   = cnt_end ? '0 : cnt_q + CW'(1);
        state_d = cnt_end ? SHIFT : SETTLE;
        bit_d   = '0;
      end
      SHIFT: begin
        cnt_d = cnt_end ? '0 : cnt_q + CW'(1);
        if (cnt_end) begin
          ph_d = !ph_q;
          if (!ph_q) shift_d = {shift_q[N-2:0], sync_q[1]};
          else if (bit_q == BW'(N - 1)) state_d = COMPARE;
          else bit_d = bit_q + BW'(1);
        end
      end
      COMPARE: begin
        state_d   = IDLE;
        dwell_d   = DW'(C_REFRESH_CYCLES);
        prev_d    = shift_q;
        prev_ok_d = 1'b1;
        out_d     = (prev_ok_q && shift_q == prev_q) ? shift_q : out_q;
        valid_d   = valid_q | (prev_ok_q && shift_q == prev_q);
        mism_d    = prev_ok_q && shift_q != prev_q;
      end
      default: state_d = IDLE;
    endcase
    load_n_d = state_d != LOAD;
  end
  // State and datapath registers; outputs come straight from flops so the chain sees clean strobes
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      ph_q      <= 1'b0;
      shift_q   <= '0;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      dwell_q   <= DW'(1);
      out_q     <= '0;
      valid_q   <= 1'b0;
      mism_q    <= 1'b0;
      load_n_q  <= 1'b1;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      ph_q      <= ph_d;
      shift_q   <= shift_d;
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
      dwell_q   <= dwell_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      mism_q    <= mism_d;
      load_n_q  <= load_n_d;
      sync_q    <= {sync_q[0], id_sdata};
    end
  end
endmodule

// File: tb/tb_board_id_reader.sv
// tb_board_id_reader: directed checks of scan waveform, bit order, debounce, rescan and reset behaviour
module tb_board_id_reader;
  localparam int D = 4, R = 200, N = 8, SL = 2 * D + 2 * N * D + 1;
  logic       clk = 1'b0, rst_n = 1'b0, rescan = 1'b0;
  logic       load_n, sclk, sdata, valid, mism, busy;
  logic [3:0] btype, brev;
  logic [7:0] word = 8'h35, sr = 8'h00;
  int checks = 0, failures = 0, cyc = 0, mism_n = 0, sclk_n = 0;

  typedef struct {
    logic [7:0] w;
    logic [3:0] t;
    logic [3:0] r;
    logic       m;
  } vec_t;
  vec_t vecs [5];

  board_id_reader #(
    .C_BOARD_TYPE_WIDTH(4), .C_BOARD_REV_WIDTH(4), .C_SCLK_DIV(D), .C_REFRESH_CYCLES(R)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .id_load_n(load_n), .id_sclk(sclk),
    .id_sdata(sdata), .rescan(rescan), .board_type(btype), .board_rev(brev),
    .id_valid(valid), .id_mismatch(mism), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mism) mism_n <= mism_n + 1;
  always @(posedge sclk) sclk_n <= sclk_n + 1;
  always @(posedge sclk or negedge load_n) sr <= !load_n ? word : {sr[6:0], 1'b0};
  assign sdata = sr[7];

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_rescan();
    rescan = 1'b1;
    @(posedge clk);
    #1 rescan = 1'b0;
  endtask

  task automatic scan(input int rs_at, output int w, output int len, output int edges,
                      output int werr, output logic mp);
    int e0;
    logic el, es;
    w = 0; len = 0; werr = 0; edges = 0; mp = 1'b0;
    do begin
      @(negedge clk);
      w++;
    end while (!busy && w < 1000);
    if (!busy) begin
      checks++;
      failures++;
      $display("FAIL scan_start_timeout: busy never rose after %0d cycles", w);
      return;
    end
    e0 = sclk_n;
    while (busy && len < 300) begin
      el = !(len < D);
      es = (len >= 2 * D && len < 2 * D + 2 * N * D) ? (((len - 2 * D) / D) % 2 == 1) : 1'b0;
      if (load_n !== el || sclk !== es) werr++;
      rescan = (len == rs_at);
      len++;
      @(negedge clk);
    end
    rescan = 1'b0;
    edges = sclk_n - e0;
    mp = mism;
  endtask

  initial begin
    int w, len, edges, werr, c0;
    logic mp;
    logic [3:0] pt, pr;
    vecs[0] = '{w: 8'h81, t: 4'h8, r: 4'h1, m: 1'b1};
    vecs[1] = '{w: 8'h7E, t: 4'h7, r: 4'hE, m: 1'b1};
    vecs[2] = '{w: 8'h7E, t: 4'h7, r: 4'hE, m: 1'b0};
    vecs[3] = '{w: 8'h35, t: 4'h3, r: 4'h5, m: 1'b1};
    vecs[4] = '{w: 8'h92, t: 4'h9, r: 4'h2, m: 1'b1};

    repeat (3) @(negedge clk);
    check("rst_load_n", load_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_type", btype, 0);
    check("rst_rev", brev, 0);
    check("rst_valid", valid, 0);
    check("rst_mismatch", mism, 0);
    check("rst_busy", busy, 0);

    rst_n = 1'b1;
    c0 = cyc;
    scan(-1, w, len, edges, werr, mp);
    check("s1_dwell", w, 1);
    check("s1_len", len, SL);
    check("s1_sclk_edges", edges, N);
    check("s1_waveform_errs", werr, 0);
    check("s1_valid", valid, 0);
    check("s1_outputs", {btype, brev}, 8'h00);
    scan(-1, w, len, edges, werr, mp);
    check("s2_refresh_dwell", w, R);
    check("s2_first_valid_cycle", cyc - c0, 1 + 2 * SL + R);
    check("s2_valid", valid, 1);
    check("s2_type", btype, 4'h3);
    check("s2_rev", brev, 4'h5);
    check("s2_no_mismatch", mism_n + int'(mp), 0);

    pt = 4'h3; pr = 4'h5;
    for (int i = 0; i < 5; i++) begin
      word = vecs[i].w;
      repeat (49) @(negedge clk);
      pulse_rescan();
      scan(-1, w, len, edges, werr, mp);
      check($sformatf("v%0d_rescan_latency", i), w, 1);
      check($sformatf("v%0d_len", i), len, SL);
      check($sformatf("v%0d_mismatch_pulse", i), mp, vecs[i].m);
      check($sformatf("v%0d_held", i), {btype, brev, valid}, {pt, pr, 1'b1});
      @(negedge clk);
      check($sformatf("v%0d_mismatch_width", i), mism, 0);
      pulse_rescan();
      scan(-1, w, len, edges, werr, mp);
      check($sformatf("v%0d_no_mismatch", i), mp, 0);
      check($sformatf("v%0d_outputs", i), {btype, brev, valid}, {vecs[i].t, vecs[i].r, 1'b1});
      pt = vecs[i].t; pr = vecs[i].r;
    end

    pulse_rescan();
    scan(2 * D + 22, w, len, edges, werr, mp);
    check("midshift_rescan_len", len, SL);
    check("midshift_rescan_edges", edges, N);
    check("midshift_rescan_wave", werr, 0);
    scan(-1, w, len, edges, werr, mp);
    check("midshift_rescan_not_queued", w, R);

    pulse_rescan();
    repeat (30) @(negedge clk);
    check("pre_reset_busy", {busy, valid}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {load_n, sclk, busy, valid, mism, btype, brev}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    scan(-1, w, len, edges, werr, mp);
    check("post_reset_s1_dwell", w, 1);
    check("post_reset_s1", {btype, brev, valid}, 9'h000);
    scan(-1, w, len, edges, werr, mp);
    check("post_reset_s2", {btype, brev, valid}, {4'h9, 4'h2, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/board_id_reader.md
# board_id_reader

Reads the board type and revision straps through an external 74HC165-style parallel-in/serial-out shift-register chain. It periodically rescans the chain and presents debounced, stable values. Its `board_type`/`board_rev` outputs drive the board type/revision inputs of the system version register block directly, in the same clock domain. Outputs update only after two consecutive identical scans.

## Interface
Parameters:
- `C_BOARD_TYPE_WIDTH`, 4: board type width; must equal the version block's.
- `C_BOARD_REV_WIDTH`, 4: board revision width; must equal the version block's.
- `C_SCLK_DIV`, 8: `id_sclk` half-period in clock cycles; must be ≥ 4.
- `C_REFRESH_CYCLES`, 1000000: IDLE dwell between scans, in clock cycles; must be ≥ 2.

Ports:
- `s_axi_aclk`, in, 1: the only clock. All logic is on its rising edge.
- `s_axi_aresetn`, in, 1: asynchronous, active-low reset.
- `id_load_n`, out, 1: parallel-load strobe to the chain, active low.
- `id_sclk`, out, 1: shift clock to the chain.
- `id_sdata`, in, 1: serial data from the chain (QH). Asynchronous.
- `rescan`, in, 1: single-cycle request for an immediate scan.
- `board_type`, out, `C_BOARD_TYPE_WIDTH`: stable board type.
- `board_rev`, out, `C_BOARD_REV_WIDTH`: stable board revision.
- `id_valid`, out, 1: high once the first stable value is captured. Sticky until reset.
- `id_mismatch`, out, 1: one-cycle pulse when a scan differs from the previous scan.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- N = `C_BOARD_TYPE_WIDTH` + `C_BOARD_REV_WIDTH`. A scan word is interpreted as {`board_type`, `board_rev`}.
- The first bit sampled is bit N-1. Bits are shifted in MSB-first (shift left, new bit into bit 0).
- `id_sdata` passes through a 2-flop synchronizer, reset to 0. Only the synchronized value is sampled.
- FSM:
  - **IDLE:** `load_n`=1, `sclk`=0. The dwell counter runs. Go to LOAD when the counter expires or when `rescan`=1 (the same cycle the counter expires or `rescan` is seen).
  - **LOAD:** `id_load_n`=0 for `C_SCLK_DIV` cycles, then go to SETTLE.
  - **SETTLE:** `id_load_n`=1 for `C_SCLK_DIV` cycles, then go to SHIFT.
  - **SHIFT:** N bit periods. Each bit period is:
    - `id_sclk`=0 for `C_SCLK_DIV` cycles; the synced data is sampled in the last of these cycles;
    - then `id_sclk`=1 for `C_SCLK_DIV` cycles.
    - After bit N, go to COMPARE.
  - **COMPARE:** one cycle, then go to IDLE.
- COMPARE rules (`prev` is the previous scan word, `prev_ok` says whether it is valid):
  - If `prev_ok` and scan == `prev`: load `board_type`/`board_rev` from the scan and set `id_valid`=1.
  - If `prev_ok` and scan ≠ `prev`: pulse `id_mismatch` for 1 cycle. Outputs hold.
  - Always: `prev` ← scan and `prev_ok` ← 1.
- Dwell after reset is 1 cycle. After every COMPARE, dwell is `C_REFRESH_CYCLES` cycles.
- `rescan` outside IDLE is ignored (not queued). `rescan` in IDLE restarts the dwell count on return to IDLE.
- `id_valid` never falls except on reset. Later stable changes update the outputs without a glitch (single-cycle register load).

## Timing
- Reset values:
  - `id_load_n`=1, `id_sclk`=0, `board_type`=0, `board_rev`=0;
  - `id_valid`=0, `id_mismatch`=0, `busy`=0;
  - `prev_ok`=0; FSM in IDLE with dwell 1.
- Reset is asserted asynchronously at any point, including mid-SHIFT. All outputs take their reset values immediately.
- `busy` rises the cycle LOAD is entered.
- Scan length, LOAD entry to IDLE re-entry: 2·`C_SCLK_DIV` + 2·N·`C_SCLK_DIV` + 1 cycles. For the default N=8 and DIV=8 this is 145 cycles.
- Data sample point: at least `C_SCLK_DIV` cycles after the preceding `id_sclk` rising edge (or after `id_load_n` rises). This covers the synchronizer's 2-cycle latency.
- Exactly N rising `id_sclk` edges per scan. `id_sclk` is always 0 outside SHIFT.
- `board_type`, `board_rev`, `id_valid` and `id_mismatch` change only on the clock edge that leaves COMPARE.
- First `id_valid` comes at the end of the second scan: 1 + 145 + `C_REFRESH_CYCLES` + 145 cycles after reset release (defaults). Outputs are unaffected while `busy`=1.

## Test plan
- Chain model holds type=0x3, rev=0x5; `C_SCLK_DIV`=4, `C_REFRESH_CYCLES`=200 → after scan 1: `id_valid`=0, outputs 0. After scan 2: `board_type`=3, `board_rev`=5, `id_valid`=1, exact cycle count matches the formula, `id_mismatch` never pulses.
- Bit order: chain word 0x81 → `board_type`=0x8, `board_rev`=0x1. Word 0x7E → 0x7 / 0xE.
- Waveform: `id_load_n` low exactly 4 cycles, then SETTLE for 4 cycles. `id_sclk` 4 low / 4 high, exactly 8 rising edges. `busy` high for the full 73-cycle scan (DIV=4).
- Stable 0x35, then the model changes to 0x92 → the next scan pulses `id_mismatch` for 1 cycle with outputs held at 3/5. The following scan updates outputs to 9/2 with `id_valid` staying 1.
- `rescan` pulsed mid-SHIFT → ignored, and the scan length is unchanged. `rescan` pulsed 50 cycles into IDLE → LOAD is entered the same cycle.
- Reset asserted mid-SHIFT after `id_valid`=1 → outputs return to 0, `id_load_n`=1, `id_sclk`=0, `id_valid`=0. After release, two fresh scans are needed before `id_valid`=1 again.
